sonar_pulse_tx: RTL and testbench

Transmit-side burst generator for the sonar front end. On a start request it drives a complementary square-wave burst (`tx_p`/`tx_n`) of programmable half-period and pulse count into the transducer driver. It then holds a programmable ring-down interval before signalling completion. The burst excites the echo that the receive chain later samples and filters.

---
 rtl/sonar_tx_pkg.sv | 17 +
 rtl/sonar_tx_timer.sv | 29 ++
 rtl/sonar_pulse_tx.sv | 176 +++++++++++++++++
 tb/tb_sonar_pulse_tx.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sonar_tx_pkg.sv
// Shared types and constants for the sonar transmit burst generator.
package sonar_tx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    HOLD = 2'd3
  } tx_state_t;

  localparam int CW_DEFAULT = 16;
  localparam int PW_DEFAULT = 8;

  // A programmed half-period of zero is treated as a single cycle.
  localparam int HP_ZERO_MAP = 1;

endpackage

// File: rtl/sonar_tx_timer.sv
// Loadable down-counter shared by half-period and hold-off timing.
// Holds at zero; never wraps.
module sonar_tx_timer
  import sonar_tx_pkg::*;
#(
  parameter int CW = CW_DEFAULT
) (
  input  logic          clk,
  input  logic          load,
  input  logic [CW-1:0] load_value,
  output logic [CW-1:0] value,
  output logic          zero
);

  logic [CW-1:0] cnt;

  // Load takes precedence; otherwise count down and stick at zero.
  always_ff @(posedge clk) begin
    if (load) begin
      cnt <= load_value;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign value = cnt;
  assign zero  = (cnt == '0);

endmodule

// File: rtl/sonar_pulse_tx.sv
// Complementary square-wave burst generator with ring-down hold-off.
// Optional feature macro: SONAR_TX_DEADTIME_EN inserts min(DT, H-1) dead
// cycles at the start of every half-period without changing the period.
module sonar_pulse_tx
  import sonar_tx_pkg::*;
#(
  parameter int CW = CW_DEFAULT,
  parameter int PW = PW_DEFAULT,
  parameter int DT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [CW-1:0] half_period,
  input  logic [PW-1:0] n_pulses,
  input  logic [CW-1:0] holdoff,
  output logic          tx_p,
  output logic          tx_n,
  output logic          busy,
  output logic          done
);

  tx_state_t     state, state_next;

  // Burst parameters captured at start
  logic [CW-1:0] h_lat;
  logic [PW-1:0] n_lat;
  logic [CW-1:0] d_lat;
  logic [CW-1:0] h_in_eff;

  logic [PW-1:0] pulse_cnt, pulse_cnt_inc;
  logic          accept, cnt_step, done_next;

  logic          tmr_load, tmr_zero;
  logic [CW-1:0] tmr_load_value, tmr_value, tmr_next;

  logic          tx_p_next, tx_n_next, busy_next, dead;

  assign h_in_eff      = (half_period == '0) ? CW'(HP_ZERO_MAP) : half_period;
  assign pulse_cnt_inc = pulse_cnt + 1'b1;

  sonar_tx_timer #(.CW(CW)) u_timer (
    .clk        (clk),
    .load       (tmr_load),
    .load_value (tmr_load_value),
    .value      (tmr_value),
    .zero       (tmr_zero)
  );

  // Timer value seen in the next cycle, so outputs can be registered in step with the FSM.
  assign tmr_next = tmr_load ? tmr_load_value : (tmr_zero ? '0 : tmr_value - 1'b1);

  // State register, pulse counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pulse_cnt <= '0;
      tx_p      <= 1'b0;
      tx_n      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        pulse_cnt <= '0;
      end else if (cnt_step) begin
        pulse_cnt <= pulse_cnt_inc;
      end
      tx_p <= tx_p_next;
      tx_n <= tx_n_next;
      busy <= busy_next;
      done <= done_next;
    end
  end

  // Burst parameters are captured only when a burst is accepted.
  always_ff @(posedge clk) begin
    if (accept) begin
      h_lat <= h_in_eff;
      n_lat <= n_pulses;
      d_lat <= holdoff;
    end
  end

  // Next-state logic; abort outranks both start and normal progress.
  always_comb begin
    state_next     = state;
    tmr_load       = 1'b0;
    tmr_load_value = '0;
    accept         = 1'b0;
    cnt_step       = 1'b0;
    done_next      = 1'b0;
    case (state)
      IDLE: begin
        if (!abort && start) begin
          if (n_pulses != '0) begin
            state_next     = HIGH;
            accept         = 1'b1;
            tmr_load       = 1'b1;
            tmr_load_value = h_in_eff - 1'b1;
          end else begin
            done_next = 1'b1;
          end
        end
      end
      HIGH: begin
        if (abort) begin
          state_next = IDLE;
        end else if (tmr_zero) begin
          state_next     = LOW;
          tmr_load       = 1'b1;
          tmr_load_value = h_lat - 1'b1;
        end
      end
      LOW: begin
        if (abort) begin
          state_next = IDLE;
        end else if (tmr_zero) begin
          cnt_step = 1'b1;
          if (pulse_cnt_inc == n_lat) begin
            if (d_lat != '0) begin
              state_next     = HOLD;
              tmr_load       = 1'b1;
              tmr_load_value = d_lat - 1'b1;
            end else begin
              state_next = IDLE;
              done_next  = 1'b1;
            end
          end else begin
            state_next     = HIGH;
            tmr_load       = 1'b1;
            tmr_load_value = h_lat - 1'b1;
          end
        end
      end
      HOLD: begin
        if (abort) begin
          state_next = IDLE;
        end else if (tmr_zero) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef SONAR_TX_DEADTIME_EN
  localparam logic [CW-1:0] DT_C = CW'(DT);
  logic [CW-1:0] h_cur, h_cur_m1, dt_eff;

  // Dead while fewer than min(DT, H-1) cycles of the half-period have elapsed.
  always_comb begin
    h_cur    = accept ? h_in_eff : h_lat;
    h_cur_m1 = h_cur - 1'b1;
    dt_eff   = (DT_C < h_cur_m1) ? DT_C : h_cur_m1;
    dead     = (tmr_next > (h_cur_m1 - dt_eff));
  end
`else
  localparam int unused_dt = DT;

  // Drive is active for the whole half-period.
  always_comb begin
    dead = 1'b0;
  end
`endif

  // Output decode from the next state; drives are mutually exclusive by state.
  always_comb begin
    tx_p_next = (state_next == HIGH) && !dead;
    tx_n_next = (state_next == LOW) && !dead;
    busy_next = (state_next != IDLE);
  end

endmodule

// File: tb/tb_sonar_pulse_tx.sv
// Self-checking bench for sonar_pulse_tx with a cycle-offset reference model.
module tb_sonar_pulse_tx;

  localparam int CW = 16;
  localparam int PW = 8;
  localparam int DT = 2;

  logic          clk = 1'b0;
  logic          rst, start, abort;
  logic [CW-1:0] half_period, holdoff;
  logic [PW-1:0] n_pulses;
  logic          tx_p, tx_n, busy, done;

  int total = 0;
  int bad   = 0;

  logic [3:0] obs_q[$];
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  sonar_pulse_tx #(.CW(CW), .PW(PW), .DT(DT)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .half_period (half_period),
    .n_pulses    (n_pulses),
    .holdoff     (holdoff),
    .tx_p        (tx_p),
    .tx_n        (tx_n),
    .busy        (busy),
    .done        (done)
  );

  // Expected {tx_p, tx_n, busy, done} in cycle k+t for a burst started at edge k.
  function automatic logic [3:0] model(input int h, input int n, input int d, input int t);
    int he, dte, p, ph;
    logic [3:0] r;
    he = (h == 0) ? 1 : h;
`ifdef SONAR_TX_DEADTIME_EN
    dte = (DT < he - 1) ? DT : he - 1;
`else
    dte = 0;
`endif
    r = 4'b0000;
    if (n == 0) begin
      if (t == 1) r = 4'b0001;
      return r;
    end
    p = 2 * he * n;
    if (t >= 1 && t <= p) begin
      ph = (t - 1) % (2 * he);
      if (ph < he) r[3] = (ph >= dte);
      else         r[2] = ((ph - he) >= dte);
      r[1] = 1'b1;
    end else if (t > p && t <= p + d) begin
      r[1] = 1'b1;
    end else if (t == p + d + 1) begin
      r[0] = 1'b1;
    end
    return r;
  endfunction

  // Run one burst from the current negedge; fills obs_q/exp_q. Ends at the
  // negedge of the done cycle (or the cycle after an abort/reset) so a following
  // call samples its start there.
  task automatic play(input int h, input int n, input int d,
                      input int abort_at, input int rst_at, input bit noise);
    int he, len;
    obs_q.delete();
    exp_q.delete();
    he  = (h == 0) ? 1 : h;
    len = (n == 0) ? 1 : 2 * he * n + d + 1;
    half_period = CW'(h);
    n_pulses    = PW'(n);
    holdoff     = CW'(d);
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int t = 1; t <= len; t++) begin
      obs_q.push_back({tx_p, tx_n, busy, done});
      exp_q.push_back(model(h, n, d, t));
      start = 1'b0;
      if (t == abort_at || t == rst_at) begin
        if (t == abort_at) abort = 1'b1;
        if (t == rst_at)   rst   = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        rst   = 1'b0;
        obs_q.push_back({tx_p, tx_n, busy, done});
        exp_q.push_back(4'b0000);
        return;
      end
      if (t < len) begin
        if (noise) begin
          half_period = CW'($urandom_range(0, 9));
          n_pulses    = PW'($urandom_range(0, 9));
          holdoff     = CW'($urandom_range(0, 9));
          start       = ($urandom_range(0, 3) == 0);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    half_period = '0; n_pulses = '0; holdoff = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({tx_p, tx_n, busy, done} !== 4'b0000) begin
        bad++;
        $display("FAIL reset cycle %0d: got %b want 0000", i, {tx_p, tx_n, busy, done});
      end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    play(3, 2, 4, 0, 0, 1'b0);
    foreach (obs_q[i]) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL basic k+%0d: got %b want %b", i + 1, obs_q[i], exp_q[i]);
      end
    end
    @(negedge clk);
    total++;
    if ({tx_p, tx_n, busy, done} !== 4'b0000) begin
      bad++;
      $display("FAIL basic_idle_after: got %b want 0000", {tx_p, tx_n, busy, done});
    end
  endtask

  task automatic test_zero_half();
    play(0, 1, 0, 0, 0, 1'b0);
    foreach (obs_q[i]) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL zero_half k+%0d: got %b want %b", i + 1, obs_q[i], exp_q[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_zero_pulses_and_ignored_start();
    play(5, 0, 3, 0, 0, 1'b0);
    foreach (obs_q[i]) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL zero_pulses k+%0d: got %b want %b", i + 1, obs_q[i], exp_q[i]);
      end
    end
    @(negedge clk);
    play(3, 2, 4, 0, 0, 1'b1);
    foreach (obs_q[i]) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL ignored_start k+%0d: got %b want %b", i + 1, obs_q[i], exp_q[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_abort_and_rst();
    for (int mode = 0; mode < 2; mode++) begin
      play(3, 2, 4, (mode == 0) ? 5 : 0, (mode == 1) ? 5 : 0, 1'b0);
      foreach (obs_q[i]) begin
        total++;
        if (obs_q[i] !== exp_q[i]) begin
          bad++;
          $display("FAIL %s k+%0d: got %b want %b", (mode == 0) ? "abort" : "rst_mid",
                   i + 1, obs_q[i], exp_q[i]);
        end
      end
      play(3, 2, 4, 0, 0, 1'b0);
      foreach (obs_q[i]) begin
        total++;
        if (obs_q[i] !== exp_q[i]) begin
          bad++;
          $display("FAIL restart_%0d k+%0d: got %b want %b", mode, i + 1, obs_q[i], exp_q[i]);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_abort_in_idle();
    half_period = 16'd2; n_pulses = 8'd1; holdoff = 16'd0;
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({tx_p, tx_n, busy, done} !== 4'b0000) begin
        bad++;
        $display("FAIL abort_idle cycle %0d: got %b want 0000", i, {tx_p, tx_n, busy, done});
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int h, n, d;
    for (int b = 0; b < 3; b++) begin
      h = $urandom_range(1, 4);
      n = $urandom_range(1, 3);
      d = $urandom_range(0, 3);
      play(h, n, d, 0, 0, 1'b0);
      foreach (obs_q[i]) begin
        total++;
        if (obs_q[i] !== exp_q[i]) begin
          bad++;
          $display("FAIL back_to_back b%0d H=%0d N=%0d D=%0d k+%0d: got %b want %b",
                   b, h, n, d, i + 1, obs_q[i], exp_q[i]);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    int h, n, d;
    for (int r = 0; r < 25; r++) begin
      h = $urandom_range(0, 6);
      n = $urandom_range(0, 4);
      d = $urandom_range(0, 6);
      play(h, n, d, 0, 0, 1'b1);
      foreach (obs_q[i]) begin
        total++;
        if (obs_q[i] !== exp_q[i]) begin
          bad++;
          $display("FAIL random r%0d H=%0d N=%0d D=%0d k+%0d: got %b want %b",
                   r, h, n, d, i + 1, obs_q[i], exp_q[i]);
        end
      end
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_max_pulses();
    play(1, 255, 2, 0, 0, 1'b0);
    foreach (obs_q[i]) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL max_pulses k+%0d: got %b want %b", i + 1, obs_q[i], exp_q[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_deadtime();
    play(4, 1, 0, 0, 0, 1'b0);
    foreach (obs_q[i]) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL deadtime_h4 k+%0d: got %b want %b", i + 1, obs_q[i], exp_q[i]);
      end
    end
    @(negedge clk);
    play(1, 3, 1, 0, 0, 1'b0);
    foreach (obs_q[i]) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL deadtime_h1 k+%0d: got %b want %b", i + 1, obs_q[i], exp_q[i]);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    half_period = '0; n_pulses = '0; holdoff = '0;
    test_reset();
    test_basic();
    test_zero_half();
    test_zero_pulses_and_ignored_start();
    test_abort_and_rst();
    test_abort_in_idle();
    test_back_to_back();
    test_random();
    test_max_pulses();
    test_deadtime();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
